pad_operand_deserializer: RTL
=============================

# pad_operand_deserializer

Upstream feeder for the 16x16 approximate multiplier in the pad-driven test path. Receives operands A and B serially from the chip pads, LSB first, one bit per clock while a frame-enable pad is high. Assembles both operands and presents them to the multiplier wrapper over a valid/ready handshake. Replaces ad-hoc pad accumulation with synchronized inputs, explicit framing, abort detection and overrun flagging.

## Interface
- WIDTH, 16, operand width in bits; frame length in cycles
- wb_clk_i  in  1  clock, shared with the Wishbone domain
- wb_rst_ni  in  1  asynchronous, active-low reset
- ser_en_i  in  1  frame enable pad (io_in[3]), asynchronous to wb_clk_i
- ser_a_i  in  1  serial A bit pad (io_in[0])
- ser_b_i  in  1  serial B bit pad (io_in[1])
- op_ready_i  in  1  downstream accepts operands
- clr_err_i  in  1  clears overrun_o
- op_a_o  out  WIDTH  assembled operand A
- op_b_o  out  WIDTH  assembled operand B
- op_valid_o  out  1  operands valid, held until accepted
- busy_o  out  1  state != IDLE
- abort_o  out  1  one-cycle pulse: frame ended short
- overrun_o  out  1  sticky: new frame started while operands pending

## Operation
- ser_en_i, ser_a_i, ser_b_i each pass through a 2-flop synchronizer (reset 0). FSM uses only the synchronized versions en_s, a_s, b_s.
- Edge detector: en_d register, reset value 1. A frame start is en_s=1 with en_d=0. After reset, en_s must be seen low before a frame is accepted.
- Shift registers sh_a and sh_b are WIDTH bits. A 5-bit counter cnt (log2(WIDTH)+1) indexes the bit being written.
- States: IDLE, SHIFT, HOLD, WAIT_DROP. Reset state is IDLE.
- IDLE:
  - On frame start, write a_s/b_s to bit 0, set cnt=1, go to SHIFT.
- SHIFT:
  - If en_s=1, write a_s/b_s to bit cnt and increment cnt.
  - On the write with cnt=WIDTH-1, load op_a_o/op_b_o from the full shift value (including the current bit), set op_valid_o=1 and go to HOLD.
  - If en_s=0 before WIDTH bits, pulse abort_o for 1 cycle, clear cnt, go to IDLE. op_a_o/op_b_o are unchanged.
- HOLD:
  - op_valid_o=1. op_a_o/op_b_o are stable.
  - On op_ready_i=1, clear op_valid_o next cycle. Go to WAIT_DROP if en_s=1, else IDLE.
  - A frame start seen in HOLD sets overrun_o. That frame's bits are discarded.
- WAIT_DROP:
  - Ignore all bits. Go to IDLE when en_s=0.
- Enable held longer than WIDTH cycles: the extra bits are ignored. Only one op_valid_o per frame.
- overrun_o is cleared by clr_err_i. If set and clear happen in the same cycle, set wins.
- Reset values: op_a_o=0, op_b_o=0, op_valid_o=0, busy_o=0, abort_o=0, overrun_o=0, cnt=0, sh_a=sh_b=0.
- Reset asserted mid-frame or during HOLD: all state returns to the reset values immediately. The pending operand is lost.

## Timing
- Pad bit k is sampled at edge E(k), k=0..WIDTH-1. It reaches the synchronizer output after E(k+1) and is written by the FSM at E(k+2).
- op_valid_o rises after E(WIDTH+1) (E17 for WIDTH=16). Latency is 18 edges from the first pad bit.
- Handshake completes on any edge with op_valid_o=1 and op_ready_i=1. op_valid_o is low in the following cycle.
- Minimum frame spacing: en_s low for at least 1 synchronized cycle between frames.
- abort_o is high for exactly the cycle after the FSM samples en_s=0 in SHIFT.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Full frame, A=0xA5C3, B=0x1234, op_ready_i=1 -> op_valid_o high one cycle after E17 with op_a_o=0xA5C3 and op_b_o=0x1234. busy_o returns to 0.
- Same frame with op_ready_i low for 5 cycles after valid -> op_valid_o held 6 cycles with operands stable, then drops one cycle after ready.
- Enable high for only 7 cycles -> abort_o single pulse, no op_valid_o, outputs unchanged. A following full frame A=0xFFFF, B=0x0001 delivers correctly.
- Second frame started while HOLD is pending (op_ready_i=0) -> overrun_o=1, first operands unchanged, no second valid. clr_err_i pulse -> overrun_o=0. Simultaneous set and clear -> overrun_o=1.
- Enable held high for 20 cycles with A=0x8001 in the first 16 bits -> exactly one op_valid_o with op_a_o=0x8001. No new frame until en is low then high.
- wb_rst_ni pulsed low mid-SHIFT with en still high at release -> all outputs 0, no frame accepted until en goes low then high. Next frame delivers correctly.

Source files
------------

// File: rtl/pad_operand_deserializer.sv
// pad_operand_deserializer
// Collects two WIDTH-bit operands shifted in LSB first from asynchronous
// chip pads while a frame-enable pad is high, and hands them to the
// multiplier wrapper over a valid/ready handshake. Short frames raise a
// one-cycle abort pulse; a frame arriving while operands are still pending
// raises a sticky overrun flag.
module pad_operand_deserializer #(
  parameter int WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             ser_en_i,
  input  logic             ser_a_i,
  input  logic             ser_b_i,
  input  logic             op_ready_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  output logic             op_valid_o,
  output logic             busy_o,
  output logic             abort_o,
  output logic             overrun_o
);

  localparam int               IDX_W = $clog2(WIDTH);
  localparam int               CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    WAIT_DROP
  } state_e;

  // Pad synchronizer stages, packed as {en, b, a}.
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  // Shifts in ones after reset; bit 1 set means sync2 now carries real pad data.
  logic [1:0]       primed_q, primed_d;
  // Previous synchronized enable for rising-edge detection.
  logic             en_dly_q, en_dly_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_valid_q, op_valid_d;
  logic             busy_q, busy_d;
  logic             abort_q, abort_d;
  logic             overrun_q, overrun_d;

  logic             en_s, a_s, b_s;
  logic             frame_start;

  assign en_s = sync2_q[2];
  assign b_s  = sync2_q[1];
  assign a_s  = sync2_q[0];

  // The edge register is held at 1 until the synchronizer has flushed its
  // reset zeros, so an enable already high at reset release never looks
  // like a fresh rising edge.
  assign frame_start = en_s & ~en_dly_q;

  // Next-state logic for the synchronizers, edge detector, framing FSM and outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    sync1_d    = {ser_en_i, ser_b_i, ser_a_i};
    sync2_d    = sync1_q;
    primed_d   = {primed_q[0], 1'b1};
    en_dly_d   = primed_q[1] ? en_s : 1'b1;
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    abort_d    = 1'b0;
    // Clear first, set later in HOLD, so a simultaneous set wins.
    overrun_d  = overrun_q & ~clr_err_i;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          sh_a_d[0] = a_s;
          sh_b_d[0] = b_s;
          cnt_d     = CNT_W'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (en_s) begin
          sh_a_d[cnt_q[IDX_W-1:0]] = a_s;
          sh_b_d[cnt_q[IDX_W-1:0]] = b_s;
          if (cnt_q == LAST) begin
            // Publish the word including the bit written this cycle.
            op_a_d     = sh_a_d;
            op_b_d     = sh_b_d;
            op_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (frame_start) begin
          overrun_d = 1'b1;
        end
        if (op_ready_i) begin
          op_valid_d = 1'b0;
          // An enable still high belongs to the delivered (or overrun) frame.
          state_d    = en_s ? WAIT_DROP : IDLE;
        end
      end
      WAIT_DROP: begin
        if (!en_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state registers, cleared asynchronously on reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      primed_q   <= '0;
      en_dly_q   <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the order of these lines cannot change behaviour.
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      primed_q   <= primed_d;
      en_dly_q   <= en_dly_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      overrun_q  <= overrun_d;
    end
  end

  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;
  assign op_valid_o = op_valid_q;
  assign busy_o     = busy_q;
  assign abort_o    = abort_q;
  assign overrun_o  = overrun_q;

endmodule
